// File: rtl/eth_phy_10g_rx_gearbox.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_rx_gearbox
//
// RX gearbox for a 10GBASE-R PHY. It takes the transceiver's 32-bit raw
// parallel words and reassembles the continuous bitstream into 66-bit blocks
// (2-bit sync header + 64-bit payload). The block boundary is moved by one bit
// for each rising edge on serdes_rx_bitslip. No descrambling or header
// checking is done here.
//
// Ports:
//   clk                input   block clock
//   rst                input   synchronous reset, active high
//   gt_rx_data[31:0]   input   raw bits, bit 0 received first
//   gt_rx_valid        input   gt_rx_data carries 32 new bits this cycle
//   serdes_rx_data     output  64-bit block payload, bit 0 earliest
//   serdes_rx_hdr      output  2-bit sync header, bit 0 earliest
//   serdes_rx_valid    output  one-cycle strobe, block present
//   serdes_rx_bitslip  input   slip request (level, acted on at rising edge)
//   rx_slip_count      output  slips performed, modulo 66
//
// Build option:
//   ETH_PHY_10G_RX_GEARBOX_SLIP_CNT_EN  when defined, rx_slip_count counts
//   slips modulo 66; when undefined it is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module eth_phy_10g_rx_gearbox #(
   parameter int IN_WIDTH   = 32,
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_WIDTH-1:0]   gt_rx_data,
   input  logic                  gt_rx_valid,
   output logic [DATA_WIDTH-1:0] serdes_rx_data,
   output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
   output logic                  serdes_rx_valid,
   input  logic                  serdes_rx_bitslip,
   output logic [6:0]            rx_slip_count
);

   localparam int BLK_W = DATA_WIDTH + HDR_WIDTH;   // 66-bit block
   // Worst case occupancy is 65 leftover bits plus one fresh word.
   localparam int BUF_W = BLK_W + IN_WIDTH;
   localparam int CNT_W = 7;

   if (IN_WIDTH != 32) begin : g_bad_in_width
      $error("eth_phy_10g_rx_gearbox: IN_WIDTH must be 32");
   end
   if (DATA_WIDTH != 64) begin : g_bad_data_width
      $error("eth_phy_10g_rx_gearbox: DATA_WIDTH must be 64");
   end
   if (HDR_WIDTH != 2) begin : g_bad_hdr_width
      $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must be 2");
   end

   // Bit buffer: oldest bit at position 0; positions >= cnt_q are always zero,
   // which lets a new word be merged with a plain OR.
   logic [BUF_W-1:0]      buf_q, buf_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  bitslip_prev_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
   logic                  valid_q, valid_d;

   // Intermediate views of the buffer after each per-cycle step.
   logic [BUF_W-1:0]      buf_a, buf_s;
   logic [CNT_W-1:0]      cnt_a, cnt_s;
   logic                  slip_req;
   logic                  do_slip;
   logic                  do_extract;

   always_comb begin
      buf_a      = buf_q;
      cnt_a      = cnt_q;
      buf_s      = '0;
      cnt_s      = '0;
      slip_req   = 1'b0;
      do_slip    = 1'b0;
      do_extract = 1'b0;
      buf_d      = '0;
      cnt_d      = '0;
      pend_d     = 1'b0;
      data_d     = data_q;
      hdr_d      = hdr_q;
      valid_d    = 1'b0;

      // Append the new word directly above the bits already held.
      if (gt_rx_valid) begin
         buf_a = buf_q | (BUF_W'(gt_rx_data) << cnt_q);
         cnt_a = cnt_q + CNT_W'(IN_WIDTH);
      end

      // A slip needs at least one bit to discard; otherwise it waits. A rising
      // edge arriving while a slip is already pending merges into it.
      slip_req = pend_q | (serdes_rx_bitslip & ~bitslip_prev_q);
      do_slip  = slip_req && (cnt_a != '0);
      buf_s    = do_slip ? (buf_a >> 1) : buf_a;
      cnt_s    = do_slip ? (cnt_a - CNT_W'(1)) : cnt_a;
      pend_d   = slip_req & ~do_slip;

      // Extract one block when a full 66 bits are available.
      do_extract = (cnt_s >= CNT_W'(BLK_W));
      buf_d      = buf_s;
      cnt_d      = cnt_s;
      if (do_extract) begin
         hdr_d   = buf_s[HDR_WIDTH-1:0];
         data_d  = buf_s[BLK_W-1:HDR_WIDTH];
         valid_d = 1'b1;
         buf_d   = buf_s >> BLK_W;
         cnt_d   = cnt_s - CNT_W'(BLK_W);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q          <= '0;
         cnt_q          <= '0;
         pend_q         <= 1'b0;
         bitslip_prev_q <= 1'b0;
         data_q         <= '0;
         hdr_q          <= '0;
         valid_q        <= 1'b0;
      end else begin
         buf_q          <= buf_d;
         cnt_q          <= cnt_d;
         pend_q         <= pend_d;
         bitslip_prev_q <= serdes_rx_bitslip;
         data_q         <= data_d;
         hdr_q          <= hdr_d;
         valid_q        <= valid_d;
      end
   end

   assign serdes_rx_data  = data_q;
   assign serdes_rx_hdr   = hdr_q;
   assign serdes_rx_valid = valid_q;

`ifdef ETH_PHY_10G_RX_GEARBOX_SLIP_CNT_EN
   logic [6:0] slip_cnt_q, slip_cnt_d;

   // 66 slips bring the alignment back to where it started, so count mod 66.
   always_comb begin
      slip_cnt_d = slip_cnt_q;
      if (do_slip) begin
         slip_cnt_d = (slip_cnt_q == 7'd65) ? 7'd0 : slip_cnt_q + 7'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slip_cnt_q <= '0;
      end else begin
         slip_cnt_q <= slip_cnt_d;
      end
   end

   assign rx_slip_count = slip_cnt_q;
`else
   assign rx_slip_count = '0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// -----------------------------------------------------------------------------
// Testbench for eth_phy_10g_rx_gearbox.
// Blocks are serialised into a bit queue (header bit 0 first, then data bit 0
// upward) and cut into 32-bit words. Each block the bench expects to see is
// pushed to a scoreboard queue; a monitor on the falling edge pops and compares
// every block the DUT presents with serdes_rx_valid.
// -----------------------------------------------------------------------------
module tb_eth_phy_10g_rx_gearbox;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gt_rx_data = '0;
   logic        gt_rx_valid = 1'b0;
   logic [63:0] serdes_rx_data;
   logic [1:0]  serdes_rx_hdr;
   logic        serdes_rx_valid;
   logic        serdes_rx_bitslip = 1'b0;
   logic [6:0]  rx_slip_count;

`ifdef ETH_PHY_10G_RX_GEARBOX_SLIP_CNT_EN
   localparam int SLIP_EN = 1;
`else
   localparam int SLIP_EN = 0;
`endif

   eth_phy_10g_rx_gearbox #(
      .IN_WIDTH  (32),
      .DATA_WIDTH(64),
      .HDR_WIDTH (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .gt_rx_data       (gt_rx_data),
      .gt_rx_valid      (gt_rx_valid),
      .serdes_rx_data   (serdes_rx_data),
      .serdes_rx_hdr    (serdes_rx_hdr),
      .serdes_rx_valid  (serdes_rx_valid),
      .serdes_rx_bitslip(serdes_rx_bitslip),
      .rx_slip_count    (rx_slip_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks  = 0;
   int          n_errors  = 0;
   bit          bitq[$];
   logic [65:0] exp_q[$];
   int          wcyc[$];
   int          skip      = 0;
   int          strobes   = 0;
   int          first_cyc = -1;
   int          last_cyc  = -1;

   function automatic int exp_slip(input int n);
      return (SLIP_EN != 0) ? (n % 66) : 0;
   endfunction

   task automatic check_int(input string tag, input int obs, input int expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check66(input string tag, input logic [65:0] obs, input logic [65:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      logic [65:0] blk;
      if (serdes_rx_valid === 1'b1) begin
         strobes++;
         if (first_cyc < 0) first_cyc = cyc;
         if (last_cyc >= 0) check_int("strobe_gap_gt1", int'((cyc - last_cyc) > 1), 1);
         last_cyc = cyc;
         if (skip > 0) begin
            skip--;
         end else begin
            check_int("block_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               blk = exp_q.pop_front();
               check66("block", {serdes_rx_hdr, serdes_rx_data}, blk);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_block(input logic [1:0] h, input logic [63:0] d, input bit expect_it);
      bitq.push_back(h[0]);
      bitq.push_back(h[1]);
      for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
      if (expect_it) exp_q.push_back({h, d});
   endtask

   task automatic drive(input bit v, input bit bs);
      logic [31:0] w;
      w = '0;
      if (v) begin
         for (int i = 0; i < 32; i++) w[i] = (bitq.size() != 0) ? bitq.pop_front() : 1'b0;
         wcyc.push_back(cyc);
      end
      gt_rx_data        = w;
      gt_rx_valid       = v;
      serdes_rx_bitslip = bs;
      tick();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) begin
         gt_rx_data        = $urandom;
         gt_rx_valid       = 1'($urandom_range(0, 1));
         serdes_rx_bitslip = 1'($urandom_range(0, 1));
         tick();
      end
      @(negedge clk);
      check_int("rst_valid", int'(serdes_rx_valid), 0);
      check66("rst_hdr_data", {serdes_rx_hdr, serdes_rx_data}, 66'd0);
      check_int("rst_slip_count", int'(rx_slip_count), 0);
      @(posedge clk);
      #1;
      rst               = 1'b0;
      gt_rx_data        = '0;
      gt_rx_valid       = 1'b0;
      serdes_rx_bitslip = 1'b0;
      bitq.delete();
      exp_q.delete();
      wcyc.delete();
      skip      = 0;
      strobes   = 0;
      first_cyc = -1;
      last_cyc  = -1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values, then an aligned stream of 16 blocks in 33 words.
      do_reset(4);
      for (int k = 0; k < 16; k++) push_block(2'b01, 64'(k), 1'b1);
      repeat (33) drive(1'b1, 1'b0);
      idle(3);
      check_int("aligned_strobes", strobes, 16);
      check_int("aligned_first_cyc", first_cyc, wcyc[2] + 1);
      check_int("aligned_last_cyc", last_cyc, wcyc[32] + 1);
      check_int("aligned_span", last_cyc - first_cyc, 30);
      check_int("aligned_left", exp_q.size(), 0);

      // Same stream with a 5-cycle stall after word 7.
      do_reset(2);
      for (int k = 0; k < 16; k++) push_block(2'b01, 64'(k), 1'b1);
      repeat (7) drive(1'b1, 1'b0);
      idle(5);
      repeat (26) drive(1'b1, 1'b0);
      idle(3);
      check_int("stall_strobes", strobes, 16);
      check_int("stall_first_cyc", first_cyc, wcyc[2] + 1);
      check_int("stall_span", last_cyc - first_cyc, 35);
      check_int("stall_left", exp_q.size(), 0);

      // One extra leading bit, removed by a bitslip pulse before word 1.
      do_reset(2);
      bitq.push_back(1'b1);
      for (int k = 0; k < 16; k++) push_block(2'b01, 64'hC0DE_0000_0000_0000 + 64'(k), 1'b1);
      drive(1'b0, 1'b1);
      repeat (34) drive(1'b1, 1'b0);
      idle(3);
      check_int("slip_strobes", strobes, 16);
      check_int("slip_left", exp_q.size(), 0);
      check_int("slip_count_1", int'(rx_slip_count), exp_slip(1));

      // Held bitslip = one slip; 65 more pulses restore alignment. The bits
      // before the indexed blocks form 80 filler blocks, less the 66 slipped
      // bits, so exactly 79 filler outputs precede block 0.
      do_reset(2);
      for (int k = 0; k < 80; k++) push_block(2'b01, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0);
      for (int k = 0; k < 16; k++) push_block(2'b01, 64'h5000 + 64'(k), 1'b1);
      skip = 79;
      repeat (10) drive(1'b1, 1'b1);
      check_int("held_slip_count", int'(rx_slip_count), exp_slip(1));
      repeat (64) begin
         drive(1'b1, 1'b0);
         drive(1'b1, 1'b1);
      end
      check_int("slip_count_65", int'(rx_slip_count), exp_slip(65));
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      check_int("slip_count_wrap", int'(rx_slip_count), exp_slip(66));
      repeat (58) drive(1'b1, 1'b0);
      idle(3);
      check_int("wrap_strobes", strobes, 95);
      check_int("wrap_skip_left", skip, 0);
      check_int("wrap_left", exp_q.size(), 0);

      // Mid-stream reset with 40 bits buffered, then with a slip pending.
      do_reset(2);
      for (int k = 0; k < 16; k++) push_block(2'b01, 64'h7000 + 64'(k), 1'b1);
      repeat (26) drive(1'b1, 1'b0);
      idle(2);
      check_int("mid_strobes_pre", strobes, 12);
      check_int("mid_left_pre", exp_q.size(), 4);
      exp_q.delete();
      bitq.delete();
      rst               = 1'b1;
      gt_rx_data        = $urandom;
      gt_rx_valid       = 1'b1;
      serdes_rx_bitslip = 1'b1;
      tick();
      rst = 1'b0;
      idle(4);
      check_int("mid_no_stale", strobes, 12);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_int("mid_slip_count", int'(rx_slip_count), 0);
      for (int k = 0; k < 16; k++) push_block(2'b01, 64'h9000 + 64'(k), 1'b1);
      repeat (33) drive(1'b1, 1'b0);
      idle(3);
      check_int("mid_strobes_post", strobes, 28);
      check_int("mid_left_post", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
